// File: rtl/fp_issue_arbiter.sv
// fp_issue_arbiter
//   Round-robin issue arbiter sharing the single FP arithmetic pipe and the
//   single-cycle integer pipe among hardware threads. A reservation ring keeps
//   the writeback port free of FP/integer collisions, squashes reservations of
//   rolled-back threads and reports FP pipe occupancy.
//
//   Optional feature macro: FP_ARB_PERF_EN (adds fia_perf_events).
//
//   Ports:
//     clk, reset                  clock, asynchronous active-high reset
//     ts_request[NUM_THREADS]     thread has an instruction ready
//     ts_pipe_float[NUM_THREADS]  request targets float pipe (0 = integer)
//     wb_rollback_en/_thread_idx  rollback of one thread this cycle
//     fia_grant_oh                one-hot grant (combinational)
//     fia_grant_valid             any grant this cycle
//     fia_grant_float             granted request targets the float pipe
//     fia_fp_inflight[4]          registered count of live FP ops
//     fia_wb_conflict             an integer request is blocked by a reservation
//     fia_perf_events[3]          {fp_issue, int_issue, wb_conflict_stall},
//                                 registered pulses (FP_ARB_PERF_EN only)

// Per-thread eligibility. A float request never waits on the ring: the top
// slot is empty after every shift and only a float issue fills it.
module fp_issue_arbiter_lane (
  input  logic req,
  input  logic is_float,
  input  logic rolled_back,
  input  logic int_slot_busy,
  output logic eligible,
  output logic wb_blocked
);
  always_comb begin
    eligible   = req && !rolled_back && (is_float || !int_slot_busy);
    wb_blocked = req && !rolled_back && !is_float && int_slot_busy;
  end
endmodule

module fp_issue_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int FP_LATENCY  = 5,
  parameter int INT_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         ts_request,
  input  logic [NUM_THREADS-1:0]         ts_pipe_float,
  input  logic                           wb_rollback_en,
  input  logic [$clog2(NUM_THREADS)-1:0] wb_rollback_thread_idx,
  output logic [NUM_THREADS-1:0]         fia_grant_oh,
  output logic                           fia_grant_valid,
  output logic                           fia_grant_float,
  output logic [3:0]                     fia_fp_inflight,
  output logic                           fia_wb_conflict
`ifdef FP_ARB_PERF_EN
  ,
  output logic [2:0]                     fia_perf_events
`endif
);
  localparam int TW = $clog2(NUM_THREADS);

  // Slot k: writeback happens k+1 cycles from now.
  typedef struct packed {
    logic          vld;
    logic          is_float;
    logic [TW-1:0] tid;
  } slot_t;

  slot_t [FP_LATENCY-1:0] ring_q, ring_d;
  logic  [TW-1:0]         rr_q, rr_d;
  logic  [3:0]            inflight_q, inflight_d;

  logic [NUM_THREADS-1:0] eligible, wb_blocked;
  logic                   found;
  logic [TW-1:0]          grant_idx, cand;
  logic                   grant_fire, grant_is_float;
  logic [4:0]             sq_cnt, add_v, sub_v;
  logic                   exit_float;

  // Slot 0's owner is never consulted; the entry only retires.
  logic unused_slot0_tid;
  assign unused_slot0_tid = ^ring_q[0].tid;

  // Integer issue lands in post-shift slot INT_LATENCY-1, i.e. current slot
  // INT_LATENCY.
  logic int_busy;
  assign int_busy = ring_q[INT_LATENCY].vld;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    fp_issue_arbiter_lane u_lane (
      .req           (ts_request[t]),
      .is_float      (ts_pipe_float[t]),
      .rolled_back   (wb_rollback_en && (wb_rollback_thread_idx == TW'(t))),
      .int_slot_busy (int_busy),
      .eligible      (eligible[t]),
      .wb_blocked    (wb_blocked[t])
    );
  end

  // First eligible thread at or after the rr pointer; TW-bit add wraps since
  // NUM_THREADS is a power of two.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cand = rr_q + TW'(i);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_fire      = found & ~reset;
  assign grant_is_float  = ts_pipe_float[grant_idx];
  assign fia_grant_valid = grant_fire;
  assign fia_grant_oh    = grant_fire ? (NUM_THREADS'(1) << grant_idx) : '0;
  assign fia_grant_float = grant_fire & grant_is_float;
  assign fia_wb_conflict = ~reset & (|wb_blocked);
  assign fia_fp_inflight = inflight_q;

  assign rr_d = grant_fire ? grant_idx + TW'(1) : rr_q;

  // Shift, then squash, then insert -- all for one edge.
  always_comb begin
    sq_cnt = '0;
    for (int k = 0; k < FP_LATENCY - 1; k++) ring_d[k] = ring_q[k+1];
    ring_d[FP_LATENCY-1] = '0;
    if (wb_rollback_en) begin
      for (int k = 0; k < FP_LATENCY; k++) begin
        if (ring_d[k].vld && ring_d[k].tid == wb_rollback_thread_idx) begin
          ring_d[k].vld = 1'b0;
          if (ring_d[k].is_float) sq_cnt = sq_cnt + 5'd1;
        end
      end
    end
    if (grant_fire) begin
      if (grant_is_float) begin
        ring_d[FP_LATENCY-1].vld      = 1'b1;
        ring_d[FP_LATENCY-1].is_float = 1'b1;
        ring_d[FP_LATENCY-1].tid      = grant_idx;
      end else begin
        ring_d[INT_LATENCY-1].vld      = 1'b1;
        ring_d[INT_LATENCY-1].is_float = 1'b0;
        ring_d[INT_LATENCY-1].tid      = grant_idx;
      end
    end
  end

  assign exit_float = ring_q[0].vld & ring_q[0].is_float;

  // Net occupancy change in one step, clamped so it can never wrap below 0.
  always_comb begin
    add_v      = {1'b0, inflight_q} + {4'd0, grant_fire & grant_is_float};
    sub_v      = sq_cnt + {4'd0, exit_float};
    inflight_d = (add_v > sub_v) ? 4'(add_v - sub_v) : 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring_q     <= '0;
      rr_q       <= '0;
      inflight_q <= '0;
    end else begin
      ring_q     <= ring_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FP_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fia_perf_events <= '0;
    else       fia_perf_events <= {grant_fire & grant_is_float,
                                   grant_fire & ~grant_is_float,
                                   fia_wb_conflict};
  end
`endif

endmodule

// File: tb/tb_fp_issue_arbiter.sv
module tb_fp_issue_arbiter;
  localparam int N    = 4;
  localparam int FPL  = 5;
  localparam int INTL = 1;
  localparam int TW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ts_request, ts_pipe_float;
  logic          wb_rollback_en;
  logic [TW-1:0] wb_rollback_thread_idx;
  logic [N-1:0]  fia_grant_oh;
  logic          fia_grant_valid, fia_grant_float, fia_wb_conflict;
  logic [3:0]    fia_fp_inflight;
`ifdef FP_ARB_PERF_EN
  logic [2:0]    fia_perf_events;
`endif

  fp_issue_arbiter #(.NUM_THREADS(N), .FP_LATENCY(FPL), .INT_LATENCY(INTL)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ts_request             (ts_request),
    .ts_pipe_float          (ts_pipe_float),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .fia_grant_oh           (fia_grant_oh),
    .fia_grant_valid        (fia_grant_valid),
    .fia_grant_float        (fia_grant_float),
    .fia_fp_inflight        (fia_fp_inflight),
    .fia_wb_conflict        (fia_wb_conflict)
`ifdef FP_ARB_PERF_EN
    ,
    .fia_perf_events        (fia_perf_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int tid;
    bit fl;
  } res_t;

  res_t resq[$];
  int   rr;
  int   tests = 0;
  int   fails = 0;
  bit   e_valid, e_float, e_conf;
  int   e_idx;
  logic [2:0] perf_exp;
  logic [N-1:0] obs_oh;
  logic obs_valid, obs_conf;
  logic [3:0] obs_inflight;
  logic [2:0] obs_perf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_inflight();
    int c = 0;
    foreach (resq[j]) if (resq[j].fl) c++;
    return c;
  endfunction

  function automatic void model_eval();
    bit elig[N];
    bit busy;
    int t;
    e_valid = 0; e_float = 0; e_conf = 0; e_idx = 0;
    busy = 0;
    foreach (resq[j]) if (resq[j].due == INTL + 1) busy = 1;
    for (int i = 0; i < N; i++) begin
      elig[i] = 0;
      if (ts_request[i] && !(wb_rollback_en && int'(wb_rollback_thread_idx) == i)) begin
        if (ts_pipe_float[i]) elig[i] = 1;
        else if (busy) e_conf = 1;
        else elig[i] = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      t = (rr + i) % N;
      if (!e_valid && elig[t]) begin
        e_valid = 1;
        e_idx   = t;
        e_float = ts_pipe_float[t];
      end
    end
  endfunction

  function automatic void model_commit();
    res_t nq[$];
    res_t r;
    foreach (resq[j]) begin
      r = resq[j];
      r.due--;
      if (r.due > 0 && !(wb_rollback_en && r.tid == int'(wb_rollback_thread_idx)))
        nq.push_back(r);
    end
    if (e_valid) begin
      r.due = e_float ? FPL : INTL;
      r.tid = e_idx;
      r.fl  = e_float;
      nq.push_back(r);
      rr = (e_idx + 1) % N;
    end
    resq     = nq;
    perf_exp = {e_valid & e_float, e_valid & ~e_float, e_conf};
  endfunction

  function automatic void model_reset();
    resq.delete();
    rr       = 0;
    perf_exp = '0;
  endfunction

  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] fl,
                      input logic rbe, input int rbi);
    logic [N-1:0] exp_oh;
    @(negedge clk);
    ts_request             = rq;
    ts_pipe_float          = fl;
    wb_rollback_en         = rbe;
    wb_rollback_thread_idx = rbi[TW-1:0];
    #1;
    model_eval();
    exp_oh       = e_valid ? (N'(1) << e_idx) : '0;
    obs_oh       = fia_grant_oh;
    obs_valid    = fia_grant_valid;
    obs_conf     = fia_wb_conflict;
    obs_inflight = fia_fp_inflight;
    chk("grant_valid", fia_grant_valid, logic'(e_valid));
    chk("grant_oh", fia_grant_oh, exp_oh);
    chk("grant_float", fia_grant_float, logic'(e_valid & e_float));
    chk("wb_conflict", fia_wb_conflict, logic'(e_conf));
    chk("fp_inflight", fia_fp_inflight, 4'(exp_inflight()));
`ifdef FP_ARB_PERF_EN
    obs_perf = fia_perf_events;
    chk("perf_events", fia_perf_events, perf_exp);
`endif
    @(posedge clk);
    model_commit();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1;
    ts_request = '1; ts_pipe_float = '0;
    wb_rollback_en = 1'b0; wb_rollback_thread_idx = '0;
    model_reset();
    #3;
    chk("rst_grant_valid", fia_grant_valid, 1'b0);
    chk("rst_grant_oh", fia_grant_oh, 4'b0000);
    chk("rst_inflight", fia_fp_inflight, 4'd0);
    chk("rst_conflict", fia_wb_conflict, 1'b0);
    @(negedge clk);
    ts_request = '0;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step('1, '1, 1'b0, 0);
      chk("s1_oh", obs_oh, N'(1) << (i % N));
      chk("s1_inflight", obs_inflight, 4'((i < FPL) ? i : FPL));
    end
    idle(FPL + 1);

    step(4'b0010, 4'b0010, 1'b0, 0);
    idle(3);
    step(4'b0100, 4'b0000, 1'b0, 0);
    chk("s2_blocked_conf", obs_conf, 1'b1);
    chk("s2_blocked_valid", obs_valid, 1'b0);
    step(4'b0100, 4'b0000, 1'b0, 0);
    chk("s2_granted", obs_oh, 4'b0100);
    idle(FPL + 1);

    step(4'b0010, 4'b0000, 1'b0, 0);
    step(4'b1001, 4'b0000, 1'b0, 0);
    chk("s3_grant3", obs_oh, 4'b1000);
    step(4'b1011, 4'b0000, 1'b0, 0);
    chk("s3_wrap0", obs_oh, 4'b0001);
    idle(FPL + 1);

    step(4'b0100, 4'b0100, 1'b0, 0);
    step(4'b0100, 4'b0100, 1'b0, 0);
    step(4'b0100, 4'b0100, 1'b0, 0);
    step(4'b0100, 4'b0100, 1'b1, 2);
    chk("s4_no_grant", obs_valid, 1'b0);
    chk("s4_before", obs_inflight, 4'd3);
    step('0, '0, 1'b0, 0);
    chk("s4_after", obs_inflight, 4'd0);
    idle(FPL + 1);

`ifdef FP_ARB_PERF_EN
    step(4'b0001, 4'b0001, 1'b0, 0);
    step(4'b0010, 4'b0000, 1'b0, 0);
    chk("perf_fp", obs_perf, 3'b100);
    step('0, '0, 1'b0, 0);
    chk("perf_int", obs_perf, 3'b010);
    idle(FPL + 1);
`endif

    for (int i = 0; i < 6; i++) step('1, '1, 1'b0, 0);
    @(negedge clk);
    ts_request = '1; ts_pipe_float = '1;
    #1;
    model_eval();
    chk("s5_pre_valid", fia_grant_valid, logic'(e_valid));
    #1;
    reset = 1'b1;
    #1;
    chk("s5_async_valid", fia_grant_valid, 1'b0);
    chk("s5_async_oh", fia_grant_oh, 4'b0000);
    chk("s5_async_inflight", fia_fp_inflight, 4'd0);
    ts_request = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step('1, '1, 1'b0, 0);
    chk("s5_first_grant", obs_oh, 4'b0001);
    chk("s5_inflight0", obs_inflight, 4'd0);

    for (int i = 0; i < 400; i++)
      step(N'($urandom), N'($urandom), logic'($urandom_range(0, 5) == 0),
           int'($urandom_range(0, N - 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_issue_arbiter.md
Name: fp_issue_arbiter

Overview:
Round-robin issue arbiter that shares the single floating-point arithmetic pipeline and the single-cycle integer pipeline among hardware threads.
It tracks writeback-port reservations so a long-latency FP result and a short-latency integer result never retire in the same cycle.
It sits between the thread select logic and operand fetch.
It also squashes reservations of rolled-back threads and reports FP pipeline occupancy.

Parameters:
NUM_THREADS, 4, number of requesting threads (power of 2, 2..8)
FP_LATENCY, 5, issue-to-writeback cycles for float pipe (2..8)
INT_LATENCY, 1, issue-to-writeback cycles for integer pipe (1..FP_LATENCY-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ts_request  in  NUM_THREADS  thread has an instruction ready to issue
ts_pipe_float  in  NUM_THREADS  request targets float pipe (0 = integer pipe)
wb_rollback_en  in  1  rollback this cycle
wb_rollback_thread_idx  in  $clog2(NUM_THREADS)  thread being rolled back
fia_grant_oh  out  NUM_THREADS  one-hot grant, combinational, this cycle
fia_grant_valid  out  1  any grant this cycle
fia_grant_float  out  1  granted request targets float pipe
fia_fp_inflight  out  4  registered count of live FP ops in flight
fia_wb_conflict  out  1  some request blocked only by a writeback reservation

Behaviour:
- Reset (async, active-high):
  - rr pointer = 0; all reservation slots invalid; fia_fp_inflight = 0.
  - Combinational outputs are forced 0 while reset is high.
- Reservation ring: FP_LATENCY slots, each {valid, thread_idx}. Slot k means "writeback occurs k+1 cycles from now". Every clock the slots shift down by one; slot 0 falls off.
- Eligibility: thread t is eligible when ts_request[t] is set and t is not the rollback thread while wb_rollback_en is asserted.
  - Float request: additionally requires slot FP_LATENCY-1 to be free after this cycle's shift. This is always true unless a same-cycle conflict is defined, because slot FP_LATENCY-1 is only written by a float issue.
  - Integer request: requires slot INT_LATENCY-1 (post-shift view, i.e. current slot INT_LATENCY) to be invalid.
- Arbitration:
  - Pick the first eligible thread starting at the rr pointer, ascending and wrapping modulo NUM_THREADS.
  - Latency 0: grant is combinational from registered state.
  - Exactly one grant per cycle at most.
  - On a grant, the rr pointer becomes granted index + 1 (wraps); otherwise it holds.
- Reservation update on grant:
  - Float grant writes {1, thread} into slot FP_LATENCY-1.
  - Integer grant writes into slot INT_LATENCY-1. The slot is guaranteed free by eligibility.
- Rollback: when wb_rollback_en is asserted, every slot whose thread_idx equals wb_rollback_thread_idx is invalidated in the same clock edge as the shift.
  - A grant that is being written in that same cycle is never for the rolled-back thread, by the eligibility rule.
- fia_fp_inflight:
  - +1 on a float grant.
  - −1 when a valid float-owned slot exits slot 0.
  - −(number of squashed float slots) on rollback.
  - Net update applied in one edge; never underflows.
  - To support this, slots carry an is_float bit.
- fia_wb_conflict: high when at least one integer request would be eligible except that its reservation slot is occupied.
- Simultaneous events: shift, squash, new reservation and counter update all occur on one edge, in the order shift → squash → insert.
- Reset mid-operation: all reservations and in-flight state are discarded immediately.

Optional Feature:
FP_ARB_PERF_EN.
- Defined: adds output fia_perf_events[2:0] = {fp_issue, int_issue, wb_conflict_stall}, registered one-cycle pulses for the perf-counter block, reset to 0.
- Undefined: the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- All 4 threads request float continuously from reset → grants cycle 0,1,2,3,0…; fia_fp_inflight ramps to 5 and holds at 5.
- Thread 1 issues float at cycle 0; thread 2 requests integer at cycle 4 (writeback at 5) → thread 2 is blocked at cycle 4 and fia_wb_conflict=1; thread 2 is granted at cycle 5.
- Threads 0 and 3 request with rr pointer=2 → thread 3 is granted, and the pointer becomes 0.
- Thread 2 has 3 float ops in flight; rollback of thread 2 → its slots are invalidated; fia_fp_inflight drops by 3 next cycle; a thread 2 request in the rollback cycle is not granted.
- Reset asserted asynchronously mid-stream with ring full → fia_grant_valid=0 immediately; after release, fia_fp_inflight=0 and the first grant goes to thread 0.
- FP_ARB_PERF_EN defined, one float and one integer issue → fia_perf_events pulses 3'b100 then 3'b010, each one cycle after its grant.
